// File: rtl/data_stack_ctrl.sv
// Forth data-stack controller: TOS held in a register, deeper cells spilled to a
// fixed window of a dual-port memory with one-cycle registered read latency.
module data_stack_ctrl #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 16'hFF00,
   parameter int                    STACK_DEPTH = 256
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [2:0]                           op,
   input  logic                                 op_valid,
   output logic                                 op_ready,
   input  logic [DATA_WIDTH-1:0]                push_data,
   output logic [DATA_WIDTH-1:0]                tos,
   output logic [$clog2(STACK_DEPTH+2)-1:0]     depth,
   output logic                                 empty,
   output logic                                 full,
   output logic                                 err_underflow,
   output logic                                 err_overflow,
   output logic [DATA_WIDTH-1:0]                mem_data,
   output logic [ADDR_WIDTH-1:0]                mem_write_addr,
   output logic                                 mem_we,
   output logic [ADDR_WIDTH-1:0]                mem_read_addr,
   input  logic [DATA_WIDTH-1:0]                mem_q
);

   localparam int DW = $clog2(STACK_DEPTH + 2);

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_PUSH    = 3'd1;
   localparam logic [2:0] OP_DROP    = 3'd2;
   localparam logic [2:0] OP_DUP     = 3'd3;
   localparam logic [2:0] OP_SWAP    = 3'd4;
   localparam logic [2:0] OP_OVER    = 3'd5;
   localparam logic [2:0] OP_NIP     = 3'd6;
   localparam logic [2:0] OP_REPLACE = 3'd7;

   localparam logic [DW-1:0]         FULL_D = DW'(STACK_DEPTH + 1);
   localparam logic [DW-1:0]         ONE_D  = DW'(1);
   localparam logic [DW-1:0]         TWO_D  = DW'(2);
   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO_A  = ADDR_WIDTH'(2);

   logic                  nos_valid;
   logic                  d_ge1, d_ge2, is_full;
   logic [ADDR_WIDTH-1:0] addr_top, addr_nos;
   logic [DATA_WIDTH-1:0] nxt_t;
   logic [DW-1:0]         nxt_d;
   logic                  wr, needs_nos, set_uf, set_of;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  accept, invalidate;

   assign d_ge1    = (depth != '0);
   assign d_ge2    = (depth >= TWO_D);
   assign is_full  = (depth == FULL_D);
   assign addr_top = STACK_BASE + ADDR_WIDTH'(depth) - ONE_A;
   assign addr_nos = STACK_BASE + ADDR_WIDTH'(depth) - TWO_A;

   assign mem_read_addr = d_ge2 ? addr_nos : STACK_BASE;

   // Underflow/overflow checks come first so rejected ops never wait for NOS,
   // except OVER at full, which only reaches the full check after needs_nos.
   always_comb begin
      nxt_t     = tos;
      nxt_d     = depth;
      wr        = 1'b0;
      waddr     = addr_top;
      needs_nos = 1'b0;
      set_uf    = 1'b0;
      set_of    = 1'b0;
      case (op)
         OP_PUSH: begin
            if (is_full) set_of = 1'b1;
            else begin
               nxt_t = push_data;
               nxt_d = depth + ONE_D;
               wr    = d_ge1;
            end
         end
         OP_DROP: begin
            if (!d_ge1) set_uf = 1'b1;
            else if (d_ge2) begin
               needs_nos = 1'b1;
               nxt_t     = mem_q;
               nxt_d     = depth - ONE_D;
            end else begin
               nxt_t = '0;
               nxt_d = depth - ONE_D;
            end
         end
         OP_DUP: begin
            if (!d_ge1) set_uf = 1'b1;
            else if (is_full) set_of = 1'b1;
            else begin
               wr    = 1'b1;
               nxt_d = depth + ONE_D;
            end
         end
         OP_SWAP: begin
            if (!d_ge2) set_uf = 1'b1;
            else begin
               needs_nos = 1'b1;
               wr        = 1'b1;
               waddr     = addr_nos;
               nxt_t     = mem_q;
            end
         end
         OP_OVER: begin
            if (!d_ge2) set_uf = 1'b1;
            else begin
               needs_nos = 1'b1;
               if (is_full) set_of = 1'b1;
               else begin
                  wr    = 1'b1;
                  nxt_t = mem_q;
                  nxt_d = depth + ONE_D;
               end
            end
         end
         OP_NIP: begin
            if (!d_ge2) set_uf = 1'b1;
            else nxt_d = depth - ONE_D;
         end
         OP_REPLACE: begin
            if (!d_ge1) set_uf = 1'b1;
            else nxt_t = push_data;
         end
         default: ;
      endcase
   end

   assign op_ready       = !(needs_nos && !nos_valid);
   assign accept         = op_valid && op_ready;
   assign mem_we         = accept && wr;
   assign mem_data       = tos;
   assign mem_write_addr = waddr;
   assign invalidate     = accept && ((nxt_d != depth) || wr);

   assign empty = (depth == '0);
   assign full  = is_full;

   always_ff @(posedge clock) begin
      if (reset) begin
         tos           <= '0;
         depth         <= '0;
         nos_valid     <= 1'b0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         if (accept) begin
            tos   <= nxt_t;
            depth <= nxt_d;
            if (set_uf) err_underflow <= 1'b1;
            if (set_of) err_overflow  <= 1'b1;
         end
         nos_valid <= !invalidate;
      end
   end

endmodule

// File: tb/tb_data_stack_ctrl.sv
// Scoreboard bench for data_stack_ctrl: driver queues expected results per op,
// a monitor checks them when the DUT accepts; memory is a behavioural model.
module tb_data_stack_ctrl;

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3,
                          SWAP = 3'd4, OVER = 3'd5, NIP = 3'd6, REPL = 3'd7;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  op = NOP;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [15:0] push_data = '0;
   logic [15:0] tos;
   logic [2:0]  depth;
   logic        empty, full, err_underflow, err_overflow;
   logic [15:0] mem_data, mem_write_addr, mem_read_addr, mem_q;
   logic        mem_we;

   data_stack_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .STACK_BASE(16'hFF00), .STACK_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
      .push_data(push_data), .tos(tos), .depth(depth), .empty(empty), .full(full),
      .err_underflow(err_underflow), .err_overflow(err_overflow),
      .mem_data(mem_data), .mem_write_addr(mem_write_addr), .mem_we(mem_we),
      .mem_read_addr(mem_read_addr), .mem_q(mem_q)
   );

   always #5 clock = ~clock;

   // Registered-read memory: a same-edge read of a written address returns old data.
   logic [15:0] mem [0:65535];
   always @(posedge clock) begin
      mem_q <= mem[mem_read_addr];
      if (mem_we) mem[mem_write_addr] <= mem_data;
   end

   typedef struct {
      string       name;
      int          stall;
      logic        we;
      logic [15:0] waddr;
      logic [15:0] wdata;
      logic [15:0] t;
      logic [2:0]  d;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   int   total = 0;
   int   passed = 0;
   int   stall_cnt = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   always @(negedge clock) begin
      if (reset) stall_cnt = 0;
      else if (op_valid && !op_ready) stall_cnt++;
      else if (op_valid && op_ready) begin
         if (sbq.size() == 0) begin
            total++;
            $display("FAIL unexpected_accept: got op %0d expected none", op);
         end else begin
            cur = sbq.pop_front();
            chk({cur.name, "_stall"}, stall_cnt, cur.stall);
            chk({cur.name, "_we"}, mem_we, cur.we);
            if (cur.we) begin
               chk({cur.name, "_waddr"}, mem_write_addr, cur.waddr);
               chk({cur.name, "_wdata"}, mem_data, cur.wdata);
            end
            stall_cnt = 0;
            @(posedge clock);
            #1;
            chk({cur.name, "_tos"}, tos, cur.t);
            chk({cur.name, "_depth"}, depth, cur.d);
         end
      end
   end

   task automatic do_op(input string name, input logic [2:0] o, input logic [15:0] pd,
                        input int stall, input logic we, input logic [15:0] wa,
                        input logic [15:0] wd, input logic [15:0] et, input logic [2:0] ed);
      exp_t e;
      logic acc;
      e.name = name; e.stall = stall; e.we = we; e.waddr = wa; e.wdata = wd;
      e.t = et; e.d = ed;
      sbq.push_back(e);
      op = o; push_data = pd; op_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 8 && !acc; i++) begin
         @(negedge clock);
         acc = op_ready;
         @(posedge clock);
         #1;
      end
      op_valid = 1'b0; op = NOP;
      if (!acc) begin
         total++;
         $display("FAIL %s_timeout: got no accept expected accept within 8 cycles", name);
         sbq.delete(sbq.size() - 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; op_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("rst_tos", tos, 16'h0);
      chk("rst_depth", depth, 3'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_uf", err_underflow, 1'b0);
      chk("rst_of", err_overflow, 1'b0);
      chk("rst_we", mem_we, 1'b0);

      // push x3, then drop x3
      do_op("push1", PUSH, 16'h1111, 0, 0, 16'h0, 16'h0, 16'h1111, 3'd1);
      do_op("push2", PUSH, 16'h2222, 0, 1, 16'hFF00, 16'h1111, 16'h2222, 3'd2);
      do_op("push3", PUSH, 16'h3333, 0, 1, 16'hFF01, 16'h2222, 16'h3333, 3'd3);
      chk("mem_ff00_a", mem[16'hFF00], 16'h1111);
      chk("mem_ff01_a", mem[16'hFF01], 16'h2222);
      idle(1);
      do_op("drop1", DROP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h2222, 3'd2);
      do_op("drop2", DROP, 16'h0, 1, 0, 16'h0, 16'h0, 16'h1111, 3'd1);
      do_op("drop3", DROP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0000, 3'd0);
      chk("drop_empty", empty, 1'b1);

      // swap twice, second one stalls
      do_op("pushA", PUSH, 16'h000A, 0, 0, 16'h0, 16'h0, 16'h000A, 3'd1);
      do_op("pushB", PUSH, 16'h000B, 0, 1, 16'hFF00, 16'h000A, 16'h000B, 3'd2);
      idle(1);
      do_op("swap1", SWAP, 16'h0, 0, 1, 16'hFF00, 16'h000B, 16'h000A, 3'd2);
      chk("mem_ff00_swap1", mem[16'hFF00], 16'h000B);
      do_op("swap2", SWAP, 16'h0, 1, 1, 16'hFF00, 16'h000A, 16'h000B, 3'd2);
      chk("mem_ff00_swap2", mem[16'hFF00], 16'h000A);

      // over / dup / nip / replace; replace keeps NOS valid so drop does not stall
      do_reset();
      do_op("push5", PUSH, 16'h0005, 0, 0, 16'h0, 16'h0, 16'h0005, 3'd1);
      do_op("push6", PUSH, 16'h0006, 0, 1, 16'hFF00, 16'h0005, 16'h0006, 3'd2);
      idle(1);
      do_op("over", OVER, 16'h0, 0, 1, 16'hFF01, 16'h0006, 16'h0005, 3'd3);
      do_op("dup", DUP, 16'h0, 0, 1, 16'hFF02, 16'h0005, 16'h0005, 3'd4);
      do_op("nip", NIP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0005, 3'd3);
      chk("mem_ff01_over", mem[16'hFF01], 16'h0006);
      chk("mem_ff02_dup", mem[16'hFF02], 16'h0005);
      do_op("replace", REPL, 16'h7777, 0, 0, 16'h0, 16'h0, 16'h7777, 3'd3);
      do_op("drop_after_repl", DROP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0006, 3'd2);

      // underflow
      do_reset();
      do_op("uf_drop", DROP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
      do_op("uf_swap", SWAP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
      do_op("uf_nip", NIP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
      chk("uf_flag", err_underflow, 1'b1);
      chk("uf_no_of", err_overflow, 1'b0);
      do_reset();
      chk("uf_cleared", err_underflow, 1'b0);

      // overflow at depth 5 with four memory-resident entries
      do_op("ofp1", PUSH, 16'h0001, 0, 0, 16'h0, 16'h0, 16'h0001, 3'd1);
      do_op("ofp2", PUSH, 16'h0002, 0, 1, 16'hFF00, 16'h0001, 16'h0002, 3'd2);
      do_op("ofp3", PUSH, 16'h0003, 0, 1, 16'hFF01, 16'h0002, 16'h0003, 3'd3);
      do_op("ofp4", PUSH, 16'h0004, 0, 1, 16'hFF02, 16'h0003, 16'h0004, 3'd4);
      do_op("ofp5", PUSH, 16'h0005, 0, 1, 16'hFF03, 16'h0004, 16'h0005, 3'd5);
      chk("of_full", full, 1'b1);
      chk("of_not_yet", err_overflow, 1'b0);
      do_op("of_over", OVER, 16'h0, 1, 0, 16'h0, 16'h0, 16'h0005, 3'd5);
      do_op("of_push", PUSH, 16'hFFFF, 0, 0, 16'h0, 16'h0, 16'h0005, 3'd5);
      do_op("of_dup", DUP, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0005, 3'd5);
      chk("of_flag", err_overflow, 1'b1);
      chk("of_no_uf", err_underflow, 1'b0);
      chk("of_still_full", full, 1'b1);

      idle(3);
      chk("sb_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
